// File: rtl/touch_coord_filter_pkg.sv
// Shared constants, FSM encoding and offset helper for the touch coordinate filter.
package touch_coord_filter_pkg;

    localparam logic [11:0] X_OFS  = 12'h096;
    localparam logic [11:0] X_SPAN = 12'hF6E;
    localparam logic [11:0] Y_OFS  = 12'h12C;
    localparam logic [11:0] Y_SPAN = 12'hED8;

    localparam int unsigned SCREEN_W_DEF = 800;
    localparam int unsigned SCREEN_H_DEF = 480;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADJ   = 2'd1,
        S_SCALE = 2'd2,
        S_FILT  = 2'd3
    } state_e;

    // Remove panel offset, flooring at zero and capping at the usable span.
    function automatic logic [11:0] offset_clip(input logic [11:0] raw,
                                                input logic [11:0] ofs,
                                                input logic [11:0] span);
        logic [11:0] d;
        if (raw < ofs) begin
            return '0;
        end
        d = raw - ofs;
        return (d > span) ? span : d;
    endfunction

endpackage

// File: rtl/coord_avg4.sv
// Four-sample moving-average history with a fill counter; avg_o is the value
// the output takes if din_i is pushed this cycle.
module coord_avg4
    import touch_coord_filter_pkg::*;
#(
    parameter int unsigned W = 10
) (
    input  logic         clk_i,
    input  logic         rstb_i,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] avg_o
);

    // The incoming sample is the fourth entry, so only three are stored.
    logic [W-1:0] h_q [3];
    logic [W-1:0] h_d [3];
    logic [2:0]   n_q, n_d;
    logic [W+1:0] sum;

    always_comb begin
        sum = (W+2)'(din_i) + (W+2)'(h_q[0]) + (W+2)'(h_q[1]) + (W+2)'(h_q[2]);
        avg_o = (n_q >= 3'd3) ? W'(sum >> 2) : din_i;
    end

    always_comb begin
        h_d = h_q;
        n_d = n_q;
        if (clr_i) begin
            for (int unsigned i = 0; i < 3; i++) h_d[i] = '0;
            n_d = '0;
        end else if (push_i) begin
            h_d[2] = h_q[1];
            h_d[1] = h_q[0];
            h_d[0] = din_i;
            if (n_q < 3'd4) n_d = n_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstb_i) begin
            for (int unsigned i = 0; i < 3; i++) h_q[i] <= '0;
            n_q <= '0;
        end else begin
            h_q <= h_d;
            n_q <= n_d;
        end
    end

endmodule

// File: rtl/touch_coord_filter.sv
// Touch sample post-processing: offset removal, scaling to screen, Z debounce
// and 4-sample position smoothing, one sample per four cycles.
module touch_coord_filter
    import touch_coord_filter_pkg::*;
#(
    parameter int unsigned SCREEN_W    = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H    = SCREEN_H_DEF,
    parameter int unsigned X_SCALE     = 13269,
    parameter int unsigned Y_SCALE     = 8276,
    parameter logic [11:0] Z_THRESH    = 12'h100,
    parameter int unsigned PRESS_CNT   = 2,
    parameter int unsigned RELEASE_CNT = 2
) (
    input  logic        cclk,
    input  logic        rstb,
    input  logic        sample_valid,
    input  logic [11:0] x_raw,
    input  logic [11:0] y_raw,
    input  logic [11:0] z_raw,
    output logic        ready,
    output logic [9:0]  x_scr,
    output logic [8:0]  y_scr,
    output logic        pressed,
    output logic        coord_valid,
    output logic        press_event,
    output logic        release_event
);

    localparam logic [7:0]  PRESS_TH = 8'(PRESS_CNT);
    localparam logic [7:0]  REL_TH   = 8'(RELEASE_CNT);
    localparam logic [11:0] X_MAX    = 12'(SCREEN_W - 1);
    localparam logic [11:0] Y_MAX    = 12'(SCREEN_H - 1);

    state_e      state_q, state_d;
    // xv/yv carry raw, then offset-adjusted, then scaled value through the pipeline.
    logic [11:0] xv_q, xv_d, yv_q, yv_d, xs, ys;
    logic        touched_q, touched_d;
    logic [7:0]  tcnt_q, tcnt_d, ucnt_q, ucnt_d;
    logic        pressed_q, pressed_d;
    logic [9:0]  x_scr_q, x_scr_d, x_avg;
    logic [8:0]  y_scr_q, y_scr_d, y_avg;
    logic        cv_q, cv_d, pe_q, pe_d, re_q, re_d;
    logic        push, clr;

    always_comb begin
        xs = 12'((28'(xv_q) * 28'(X_SCALE)) >> 16);
        ys = 12'((28'(yv_q) * 28'(Y_SCALE)) >> 16);
    end

    always_comb begin
        state_d   = state_q;
        xv_d      = xv_q;
        yv_d      = yv_q;
        touched_d = touched_q;
        tcnt_d    = tcnt_q;
        ucnt_d    = ucnt_q;
        pressed_d = pressed_q;
        x_scr_d   = x_scr_q;
        y_scr_d   = y_scr_q;
        cv_d      = 1'b0;
        pe_d      = 1'b0;
        re_d      = 1'b0;
        push      = 1'b0;
        clr       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    xv_d      = x_raw;
                    yv_d      = y_raw;
                    touched_d = (z_raw >= Z_THRESH);
                    state_d   = S_ADJ;
                end
            end
            S_ADJ: begin
                xv_d    = offset_clip(xv_q, X_OFS, X_SPAN);
                yv_d    = offset_clip(yv_q, Y_OFS, Y_SPAN);
                state_d = S_SCALE;
            end
            S_SCALE: begin
                xv_d    = (xs > X_MAX) ? X_MAX : xs;
                yv_d    = (ys > Y_MAX) ? Y_MAX : ys;
                state_d = S_FILT;
            end
            S_FILT: begin
                if (touched_q) begin
                    if (tcnt_q != '1) tcnt_d = tcnt_q + 8'd1;
                    ucnt_d = '0;
                end else begin
                    if (ucnt_q != '1) ucnt_d = ucnt_q + 8'd1;
                    tcnt_d = '0;
                end
                if (!pressed_q && tcnt_d >= PRESS_TH) begin
                    pressed_d = 1'b1;
                    pe_d      = 1'b1;
                end else if (pressed_q && ucnt_d >= REL_TH) begin
                    pressed_d = 1'b0;
                    re_d      = 1'b1;
                    clr       = 1'b1;
                end
                push = touched_q && pressed_d;
                if (push) begin
                    x_scr_d = x_avg;
                    y_scr_d = y_avg;
                    cv_d    = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            state_q   <= S_IDLE;
            xv_q      <= '0;
            yv_q      <= '0;
            touched_q <= 1'b0;
            tcnt_q    <= '0;
            ucnt_q    <= '0;
            pressed_q <= 1'b0;
            x_scr_q   <= '0;
            y_scr_q   <= '0;
            cv_q      <= 1'b0;
            pe_q      <= 1'b0;
            re_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            xv_q      <= xv_d;
            yv_q      <= yv_d;
            touched_q <= touched_d;
            tcnt_q    <= tcnt_d;
            ucnt_q    <= ucnt_d;
            pressed_q <= pressed_d;
            x_scr_q   <= x_scr_d;
            y_scr_q   <= y_scr_d;
            cv_q      <= cv_d;
            pe_q      <= pe_d;
            re_q      <= re_d;
        end
    end

    coord_avg4 #(.W(10)) u_avg_x (
        .clk_i  (cclk),
        .rstb_i (rstb),
        .clr_i  (clr),
        .push_i (push),
        .din_i  (xv_q[9:0]),
        .avg_o  (x_avg)
    );

    coord_avg4 #(.W(9)) u_avg_y (
        .clk_i  (cclk),
        .rstb_i (rstb),
        .clr_i  (clr),
        .push_i (push),
        .din_i  (yv_q[8:0]),
        .avg_o  (y_avg)
    );

    assign ready         = (state_q == S_IDLE);
    assign x_scr         = x_scr_q;
    assign y_scr         = y_scr_q;
    assign pressed       = pressed_q;
    assign coord_valid   = cv_q;
    assign press_event   = pe_q;
    assign release_event = re_q;

endmodule
